mac_pu_datapath: RTL and testbench
==================================

MAC_PU_DATAPATH -- requirements
Module: mac_pu_datapath

Interface
REQ-001 SHALL have parameter MAC_NUM, default 8: number of parallel multiply lanes.
REQ-002 SHALL have parameter DATA_W, default 8: signed operand and result width.
REQ-003 SHALL have parameter ACC_W, default 24: signed accumulator width.
REQ-004 SHALL have parameter SHIFT, default 4: arithmetic right shift applied at requantization.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous reset, active-high.
REQ-007 SHALL have port pu_en_i, input, 1 bit: operands on the data inputs are valid this cycle (one beat).
REQ-008 SHALL have port pu_valid_i, input, 1 bit: closes the current accumulation.
REQ-009 SHALL have port pu_clear_i, input, 1 bit: flushes the accumulator and the pipeline.
REQ-010 SHALL have port mux_ctrl_i, input, 1 bit: 0 selects act_i (layer 1), 1 selects tmp_i (layer 2).
REQ-011 SHALL have ports act_i, tmp_i and wgt_i, input, MAC_NUM*DATA_W bits each: packed signed lanes, lane 0 in the LSBs.
REQ-012 SHALL have port res_data_o, output, DATA_W bits: requantized result.
REQ-013 SHALL have port res_acc_o, output, ACC_W bits: raw accumulator value at capture.
REQ-014 SHALL have port res_valid_o, output, 1 bit: single-cycle result strobe.
REQ-015 SHALL have port res_layer_o, output, 1 bit: value of mux_ctrl_i at capture.
REQ-016 SHALL have port ovf_o, output, 1 bit: sticky accumulator-saturation flag.

Function
REQ-017 Stage 1 SHALL register MAC_NUM signed products of the selected operand and wgt_i, lane by lane, in any cycle where pu_en_i=1.
REQ-018 Stage 2 SHALL register the signed sum of the stage-1 products, of width 2*DATA_W+clog2(MAC_NUM).
REQ-019 Stage 3 SHALL add the stage-2 sum into the accumulator, saturating to the signed ACC_W range.
REQ-020 Any stage-3 saturation SHALL set ovf_o; ovf_o clears only on rst_i.
REQ-021 The valid bits of stages 1 and 2 SHALL be delayed copies of pu_en_i.
REQ-022 pu_valid_i SHALL travel through a 3-deep token delay; res_valid_o is 1 exactly 3 cycles after pu_valid_i is sampled high.
REQ-023 A result SHALL include every beat whose pu_en_i was high strictly before the pu_valid_i cycle.
REQ-024 A beat that coincides with pu_valid_i SHALL be counted in the next result.
REQ-025 At the capture edge, res_acc_o SHALL take the accumulator value.
REQ-026 At the capture edge, the accumulator SHALL reload with the concurrent stage-2 sum if one is valid, otherwise with 0.
REQ-027 Requantization SHALL compute r = acc >>> SHIFT.
REQ-028 When res_layer_o=0, res_data_o SHALL be max(r,0) saturated to 2^(DATA_W-1)-1 (ReLU).
REQ-029 When res_layer_o=1, res_data_o SHALL be r saturated to the signed DATA_W range.
REQ-030 res_data_o, res_acc_o and res_layer_o SHALL hold their values until the next capture.
REQ-031 pu_valid_i with no preceding beats SHALL produce a result of 0.
REQ-032 pu_clear_i SHALL zero the accumulator, all pipeline valid bits and all tokens on the next edge.
REQ-033 pu_clear_i SHALL take priority over pu_en_i and pu_valid_i in the same cycle; both are discarded.
REQ-034 pu_clear_i SHALL leave ovf_o and the held result registers unchanged.
REQ-035 A new pu_valid_i asserted while earlier tokens are in flight SHALL produce an independent result; back-to-back results are permitted.

Reset
REQ-036 While rst_i is high, all outputs, the accumulator, pipeline data and valid bits SHALL be 0 on the next edge.
REQ-037 rst_i mid-accumulation SHALL discard all in-flight beats and tokens; no res_valid_o pulse follows.

Structure
REQ-038 Package mac_pu_pkg SHALL hold the width constants, the product and sum width functions, and the layer-select encoding.
REQ-039 The stage-2 reduction SHALL be a sub-module adder_tree, parameterized by MAC_NUM and input width, with a registered output.

Verification
REQ-040 Layer 1, beats: all act=1, wgt=2, 4 beats, then pu_valid_i -> res_acc_o=64 and res_data_o=4, 3 cycles after pu_valid_i.
REQ-041 Layer 2, negative: mux_ctrl_i=1, tmp=1, wgt=-3, 4 beats -> res_acc_o=-96 and res_data_o=-6; the same data in layer 1 -> res_data_o=0.
REQ-042 Saturation: act=127, wgt=127, 4 beats -> res_acc_o=516128 and res_data_o=127; 66 beats -> res_acc_o=8388607 and ovf_o=1.
REQ-043 Boundary: pu_valid_i coincident with the 5th beat -> first result=64 and the next result includes that 5th beat; pu_valid_i alone -> res_acc_o=0.
REQ-044 Flush: pu_clear_i after 2 beats, then 4 clean beats -> result=64; rst_i mid-run -> no res_valid_o, all outputs 0.

Source files
------------

// File: rtl/mac_pu_pkg.sv
// Shared constants, width helpers and layer-select encoding for the MAC processing-unit datapath.
package mac_pu_pkg;

    localparam int MAC_NUM_DEF = 8;
    localparam int DATA_W_DEF  = 8;
    localparam int ACC_W_DEF   = 24;
    localparam int SHIFT_DEF   = 4;

    typedef enum logic {
        LAYER_ACT = 1'b0,
        LAYER_TMP = 1'b1
    } layer_e;

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int sum_w(input int data_w, input int mac_num);
        return 2 * data_w + $clog2(mac_num);
    endfunction

endpackage

// File: rtl/mac_pu_datapath_if.sv
// Operand, control and result bundle of the MAC processing unit.
interface mac_pu_datapath_if #(
    parameter int MAC_NUM = 8,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24
);
    // pu_en_i marks one operand beat per high cycle; pu_valid_i closes the running
    // accumulation and res_valid_o answers it with a one-cycle strobe 3 cycles later.
    // There is no back-pressure: the datapath accepts every beat and token.
    logic                          pu_en_i;
    logic                          pu_valid_i;
    logic                          pu_clear_i;
    logic                          mux_ctrl_i;
    logic [MAC_NUM*DATA_W-1:0]     act_i;
    logic [MAC_NUM*DATA_W-1:0]     tmp_i;
    logic [MAC_NUM*DATA_W-1:0]     wgt_i;
    logic [DATA_W-1:0]             res_data_o;
    logic [ACC_W-1:0]              res_acc_o;
    logic                          res_valid_o;
    logic                          res_layer_o;
    logic                          ovf_o;

    modport master (
        output pu_en_i, pu_valid_i, pu_clear_i, mux_ctrl_i, act_i, tmp_i, wgt_i,
        input  res_data_o, res_acc_o, res_valid_o, res_layer_o, ovf_o
    );

    modport slave (
        input  pu_en_i, pu_valid_i, pu_clear_i, mux_ctrl_i, act_i, tmp_i, wgt_i,
        output res_data_o, res_acc_o, res_valid_o, res_layer_o, ovf_o
    );
endinterface

// File: rtl/mac_pu_datapath_adder_tree.sv
// Registered signed reduction of N packed lanes, carrying a valid bit alongside the sum.
module adder_tree #(
    parameter int N     = 8,
    parameter int IN_W  = 16,
    parameter int OUT_W = IN_W + $clog2(N)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    vld_i,
    input  logic [N*IN_W-1:0]       in_i,
    output logic                    vld_o,
    output logic signed [OUT_W-1:0] sum_o
);

    logic signed [OUT_W-1:0] sum_c;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < N; i++) begin
            sum_c = sum_c + OUT_W'($signed(in_i[i*IN_W +: IN_W]));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_o <= 1'b0;
            sum_o <= '0;
        end else begin
            vld_o <= vld_i & ~clear_i;
            if (vld_i && !clear_i) begin
                sum_o <= sum_c;
            end
        end
    end

endmodule

// File: rtl/mac_pu_datapath.sv
// Three-stage MAC datapath: lane products, adder-tree reduction, saturating accumulator
// with token-timed capture and ReLU / signed requantization of the captured value.
module mac_pu_datapath
    import mac_pu_pkg::*;
#(
    parameter int MAC_NUM = MAC_NUM_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int SHIFT   = SHIFT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mac_pu_datapath_if.slave  bus
);

    localparam int PROD_W = prod_w(DATA_W);
    localparam int SUM_W  = sum_w(DATA_W, MAC_NUM);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Q_MAX   = ACC_W'((1 <<< (DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] Q_MIN   = ~Q_MAX;

    logic [MAC_NUM*DATA_W-1:0] op_sel;
    logic [MAC_NUM*PROD_W-1:0] prod_c, s1_prod;
    logic                      s1_vld, s2_vld;
    logic signed [SUM_W-1:0]   s2_sum;
    logic signed [ACC_W-1:0]   acc, acc_sat, r_c;
    logic signed [ACC_W:0]     acc_wide;
    logic                      ovf_c, capture;
    logic [2:0]                tok;
    logic [DATA_W-1:0]         q_c, res_data;
    logic [ACC_W-1:0]          res_acc;
    logic                      res_layer, ovf;

    assign op_sel = (bus.mux_ctrl_i == LAYER_TMP) ? bus.tmp_i : bus.act_i;

    always_comb begin
        prod_c = '0;
        for (int i = 0; i < MAC_NUM; i++) begin
            prod_c[i*PROD_W +: PROD_W] = PROD_W'($signed(op_sel[i*DATA_W +: DATA_W]))
                                       * PROD_W'($signed(bus.wgt_i[i*DATA_W +: DATA_W]));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld  <= 1'b0;
            s1_prod <= '0;
        end else begin
            s1_vld <= bus.pu_en_i & ~bus.pu_clear_i;
            if (bus.pu_en_i && !bus.pu_clear_i) begin
                s1_prod <= prod_c;
            end
        end
    end

    adder_tree #(
        .N     (MAC_NUM),
        .IN_W  (PROD_W),
        .OUT_W (SUM_W)
    ) u_adder_tree (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (bus.pu_clear_i),
        .vld_i   (s1_vld),
        .in_i    (s1_prod),
        .vld_o   (s2_vld),
        .sum_o   (s2_sum)
    );

    // One extra sign bit exposes overflow; clamp to the signed accumulator range.
    always_comb begin
        acc_wide = (ACC_W+1)'(acc) + (ACC_W+1)'(s2_sum);
        ovf_c    = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
        if (ovf_c) begin
            acc_sat = acc_wide[ACC_W] ? ~ACC_MAX : ACC_MAX;
        end else begin
            acc_sat = acc_wide[ACC_W-1:0];
        end
    end

    always_comb begin
        r_c = acc >>> SHIFT;
        if (r_c > Q_MAX) begin
            q_c = Q_MAX[DATA_W-1:0];
        end else if (bus.mux_ctrl_i == LAYER_ACT && r_c < 0) begin
            q_c = '0;
        end else if (r_c < Q_MIN) begin
            q_c = Q_MIN[DATA_W-1:0];
        end else begin
            q_c = r_c[DATA_W-1:0];
        end
    end

    // Capturing one token early keeps the beat coincident with pu_valid_i out of this result.
    assign capture = tok[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tok       <= '0;
            acc       <= '0;
            res_acc   <= '0;
            res_data  <= '0;
            res_layer <= 1'b0;
            ovf       <= 1'b0;
        end else if (bus.pu_clear_i) begin
            tok <= '0;
            acc <= '0;
        end else begin
            tok <= {tok[1:0], bus.pu_valid_i};
            if (capture) begin
                res_acc   <= acc;
                res_data  <= q_c;
                res_layer <= bus.mux_ctrl_i;
                acc       <= s2_vld ? ACC_W'(s2_sum) : '0;
            end else if (s2_vld) begin
                acc <= acc_sat;
                if (ovf_c) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    assign bus.res_valid_o = tok[2];
    assign bus.res_acc_o   = res_acc;
    assign bus.res_data_o  = res_data;
    assign bus.res_layer_o = res_layer;
    assign bus.ovf_o       = ovf;

endmodule

// File: tb/tb_mac_pu_datapath.sv
// Directed bench for mac_pu_datapath: layer selection, requantization, saturation,
// capture boundaries, flush and reset, each against hand-computed results.
module tb_mac_pu_datapath;
    import mac_pu_pkg::*;

    localparam int MAC_NUM = 8;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 24;
    localparam int SHIFT   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_pu_datapath_if #(.MAC_NUM(MAC_NUM), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    mac_pu_datapath #(
        .MAC_NUM (MAC_NUM),
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .SHIFT   (SHIFT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [MAC_NUM*DATA_W-1:0] lanes(input int v);
        logic [MAC_NUM*DATA_W-1:0] r;
        for (int i = 0; i < MAC_NUM; i++) r[i*DATA_W +: DATA_W] = DATA_W'(v);
        return r;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, sampled at the next rising edge; returns at the following negedge.
    task automatic cycle(input logic en, input logic vld, input logic clr,
                         input int a, input int t, input int w);
        bus.pu_en_i    = en;
        bus.pu_valid_i = vld;
        bus.pu_clear_i = clr;
        bus.act_i      = lanes(a);
        bus.tmp_i      = lanes(t);
        bus.wgt_i      = lanes(w);
        @(negedge clk);
        bus.pu_en_i    = 1'b0;
        bus.pu_valid_i = 1'b0;
        bus.pu_clear_i = 1'b0;
    endtask

    task automatic beats(input int n, input int a, input int t, input int w);
        repeat (n) cycle(1'b1, 1'b0, 1'b0, a, t, w);
    endtask

    task automatic wait_result(input string tag, input longint e_acc, input longint e_data,
                               input logic e_layer);
        int lat = 1;
        while (!bus.res_valid_o && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, 3);
        check({tag, ".acc"}, $signed(bus.res_acc_o), e_acc);
        check({tag, ".data"}, $signed(bus.res_data_o), e_data);
        check({tag, ".layer"}, bus.res_layer_o, e_layer);
        @(negedge clk);
        check({tag, ".strobe_end"}, bus.res_valid_o, 0);
        check({tag, ".hold"}, $signed(bus.res_acc_o), e_acc);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".acc"}, bus.res_acc_o, 0);
        check({tag, ".data"}, bus.res_data_o, 0);
        check({tag, ".layer"}, bus.res_layer_o, 0);
        check({tag, ".valid"}, bus.res_valid_o, 0);
        check({tag, ".ovf"}, bus.ovf_o, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.pu_en_i = 1'b0; bus.pu_valid_i = 1'b0; bus.pu_clear_i = 1'b0;
        bus.mux_ctrl_i = 1'b0;
        bus.act_i = '0; bus.tmp_i = '0; bus.wgt_i = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Layer 1: 8 lanes * 1*2 = 16 per beat, 4 beats = 64, 64>>>4 = 4
        bus.mux_ctrl_i = 1'b0;
        beats(4, 1, 0, 2);
        cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        wait_result("l1_basic", 64, 4, 1'b0);

        // Layer 2 picks tmp_i (act_i held at a decoy value): 8*1*-3*4 = -96, -96>>>4 = -6
        bus.mux_ctrl_i = 1'b1;
        beats(4, 5, 1, -3);
        cycle(1'b0, 1'b1, 1'b0, 5, 1, -3);
        wait_result("l2_neg", -96, -6, 1'b1);

        // Same negative data in layer 1: ReLU clamps to 0
        bus.mux_ctrl_i = 1'b0;
        beats(4, 1, 7, -3);
        cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        wait_result("l1_relu", -96, 0, 1'b0);

        // pu_valid_i on the 5th beat: that beat moves to the next result (16)
        beats(4, 1, 0, 2);
        cycle(1'b1, 1'b1, 1'b0, 1, 0, 2);
        wait_result("bnd_first", 64, 4, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        wait_result("bnd_carry", 16, 1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        wait_result("bnd_empty", 0, 0, 1'b0);

        // Back-to-back tokens: 2 beats + coincident beat -> 32, then 16
        beats(2, 1, 0, 2);
        cycle(1'b1, 1'b1, 1'b0, 1, 0, 2);
        cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        @(negedge clk);
        check("b2b_first.valid", bus.res_valid_o, 1);
        check("b2b_first.acc", $signed(bus.res_acc_o), 32);
        @(negedge clk);
        check("b2b_second.valid", bus.res_valid_o, 1);
        check("b2b_second.acc", $signed(bus.res_acc_o), 16);
        @(negedge clk);
        check("b2b_end.valid", bus.res_valid_o, 0);

        // 127*127*8 = 129032 per beat; 4 beats = 516128, >>>4 = 32258 -> clamp 127
        beats(4, 127, 0, 127);
        cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        wait_result("sat4", 516128, 127, 1'b0);
        check("sat4.ovf", bus.ovf_o, 0);

        // 66 beats = 8516112 exceeds 2^23-1, saturates and sets the sticky flag
        beats(66, 127, 0, 127);
        cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        wait_result("sat66", 8388607, 127, 1'b0);
        check("sat66.ovf", bus.ovf_o, 1);

        // Clear after 2 beats; the coincident beat and token are dropped as well
        beats(2, 1, 0, 2);
        cycle(1'b1, 1'b1, 1'b1, 1, 0, 2);
        check("clear.hold_acc", $signed(bus.res_acc_o), 8388607);
        check("clear.hold_data", $signed(bus.res_data_o), 127);
        check("clear.ovf_kept", bus.ovf_o, 1);
        repeat (3) @(negedge clk);
        check("clear.no_strobe", bus.res_valid_o, 0);
        beats(4, 1, 0, 2);
        cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        wait_result("clear_after", 64, 4, 1'b0);

        // Reset mid-run: the in-flight token must never surface
        bus.mux_ctrl_i = 1'b1;
        beats(2, 1, 1, 2);
        cycle(1'b0, 1'b1, 1'b0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mux_ctrl_i = 1'b0;
        check_all_zero("rst_mid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_mid.no_strobe", bus.res_valid_o, 0);
        end
        check("rst_mid.acc_after", bus.res_acc_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
